// File: rtl/friet_pkg.sv
// -----------------------------------------------------------------------------
// friet_pkg
// Shared definitions for the Friet permutation arbiter slice:
//   - FRIET_STATE_SIZE     : permutation state width in bits
//   - friet_words()        : number of stream words needed to move one state
//   - friet_cnt_width()    : width of a counter that indexes those words
//   - arb_state_t          : arbiter FSM encoding (IDLE..RELEASE)
// No ports (package).
// -----------------------------------------------------------------------------
package friet_pkg;

    localparam int FRIET_STATE_SIZE = 384;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_RUN     = 3'd3,
        ST_UNLOAD  = 3'd4,
        ST_RELEASE = 3'd5
    } arb_state_t;

    function automatic int friet_words(input int state_size, input int buffer_length);
        return state_size / buffer_length;
    endfunction

    function automatic int friet_cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/friet_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// friet_rr_arbiter2
// Two-way round-robin grant picker (purely combinational).
// Ports:
//   req_i [1:0]  request per requester
//   ptr_i        preferred requester when both request (0 or 1)
//   gnt_o [1:0]  one-hot grant, or 0 when nobody requests
// -----------------------------------------------------------------------------
module friet_rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/friet_permutation_arbiter.sv
// -----------------------------------------------------------------------------
// friet_permutation_arbiter
// Shares one word-serial Friet permutation core between two requesters.
// Each transaction: load full state, pulse core_start, wait core_finish,
// unload full state, release (done pulse) and hand priority to the other side.
//
// Optional feature macro: FRIET_ARB_CYCLE_COUNT_EN
//   When defined, adds output run_cycles[15:0]: saturating count of RUN cycles
//   of the most recent permutation, cleared in START.
//
// Ports:
//   clk, arst                    clock, asynchronous active-high reset
//   req[1:0] / gnt[1:0]          level request / registered one-hot grant
//   rq_data_in[2*BL-1:0]         requester words, slice i*BL +: BL is requester i
//   rq_data_in_valid/ready[1:0]  per-requester load handshake
//   rq_data_out[BL-1:0]          shared unload word
//   rq_data_out_valid/ready[1:0] per-requester unload handshake
//   done[1:0]                    one-cycle completion pulse
//   core_*                       streaming/control interface to the core
// -----------------------------------------------------------------------------
module friet_permutation_arbiter
    import friet_pkg::*;
#(
    parameter int BUFFER_LENGTH = 8,
    parameter int STATE_SIZE    = FRIET_STATE_SIZE
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [1:0]                 req,
    output logic [1:0]                 gnt,
    input  logic [2*BUFFER_LENGTH-1:0] rq_data_in,
    input  logic [1:0]                 rq_data_in_valid,
    output logic [1:0]                 rq_data_in_ready,
    output logic [BUFFER_LENGTH-1:0]   rq_data_out,
    output logic [1:0]                 rq_data_out_valid,
    input  logic [1:0]                 rq_data_out_ready,
    output logic [1:0]                 done,
    output logic                       core_start,
    output logic                       core_data_in_valid,
    output logic                       core_data_out_ready,
    output logic [BUFFER_LENGTH-1:0]   core_data_in,
    input  logic [BUFFER_LENGTH-1:0]   core_data_out,
    input  logic                       core_data_out_valid,
    input  logic                       core_data_in_ready,
    input  logic                       core_finish,
    input  logic                       core_core_free
`ifdef FRIET_ARB_CYCLE_COUNT_EN
    ,
    output logic [15:0]                run_cycles
`endif
);

    localparam int WORDS = friet_words(STATE_SIZE, BUFFER_LENGTH);
    localparam int CNT_W = friet_cnt_width(WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    arb_state_t       state_q;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic             core_start_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rr_q;

    logic [1:0]       pick;
    logic             in_load;
    logic             in_unload;
    logic             load_hs;
    logic             unload_hs;
    logic             last_word;

    friet_rr_arbiter2 u_rr (
        .req_i (req),
        .ptr_i (rr_q),
        .gnt_o (pick)
    );

    assign in_load   = (state_q == ST_LOAD);
    assign in_unload = (state_q == ST_UNLOAD);
    assign last_word = (cnt_q == LAST_WORD);

    // gnt_q stays one-hot from LOAD through UNLOAD, so it doubles as the
    // stream select; outside those states every handshake is forced low.
    assign core_data_in        = gnt_q[1] ? rq_data_in[2*BUFFER_LENGTH-1:BUFFER_LENGTH]
                                          : rq_data_in[BUFFER_LENGTH-1:0];
    assign core_data_in_valid  = in_load && |(rq_data_in_valid & gnt_q);
    assign core_data_out_ready = in_unload && |(rq_data_out_ready & gnt_q);
    assign rq_data_out         = core_data_out;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req_stream
            assign rq_data_in_ready[gi]  = in_load && gnt_q[gi] && core_data_in_ready;
            assign rq_data_out_valid[gi] = in_unload && gnt_q[gi] && core_data_out_valid;
        end
    endgenerate

    assign load_hs   = core_data_in_valid && core_data_in_ready;
    assign unload_hs = core_data_out_valid && core_data_out_ready;

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign core_start = core_start_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            core_start_q <= 1'b0;
            cnt_q        <= '0;
            rr_q         <= 1'b0;
        end else begin
            done_q       <= 2'b00;
            core_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req && core_core_free) begin
                        gnt_q   <= pick;
                        cnt_q   <= '0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_hs) begin
                        if (last_word) begin
                            cnt_q        <= '0;
                            core_start_q <= 1'b1;
                            state_q      <= ST_START;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    cnt_q   <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_finish) begin
                        cnt_q   <= '0;
                        state_q <= ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    if (unload_hs) begin
                        if (last_word) begin
                            cnt_q   <= '0;
                            done_q  <= gnt_q;
                            gnt_q   <= 2'b00;
                            // Point at whichever side did not just finish.
                            rr_q    <= ~gnt_q[1];
                            state_q <= ST_RELEASE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= 2'b00;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FRIET_ARB_CYCLE_COUNT_EN
    logic [15:0] run_cycles_q;
    logic [15:0] run_cycles_d;

    always_comb begin
        run_cycles_d = run_cycles_q;
        if (state_q == ST_START) begin
            run_cycles_d = 16'd0;
        end else if (state_q == ST_RUN && run_cycles_q != 16'hFFFF) begin
            run_cycles_d = run_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            run_cycles_q <= 16'd0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_friet_permutation_arbiter.sv
// -----------------------------------------------------------------------------
// tb_friet_permutation_arbiter
// Directed bench for friet_permutation_arbiter with a behavioural stand-in
// core. The stand-in "permutation" returns out[j] = in[47-j] ^ (0x5A + j);
// the expected words are queued when a load completes and popped per
// accepted unload word.
// -----------------------------------------------------------------------------
module tb_friet_permutation_arbiter;

    localparam int BL    = 8;
    localparam int WORDS = 48;

    logic          clk = 1'b0;
    logic          arst;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [2*BL-1:0] rq_data_in;
    logic [1:0]    rq_data_in_valid;
    logic [1:0]    rq_data_in_ready;
    logic [BL-1:0] rq_data_out;
    logic [1:0]    rq_data_out_valid;
    logic [1:0]    rq_data_out_ready;
    logic [1:0]    done;
    logic          core_start;
    logic          core_data_in_valid;
    logic          core_data_out_ready;
    logic [BL-1:0] core_data_in;
    logic [BL-1:0] core_data_out;
    logic          core_data_out_valid;
    logic          core_data_in_ready;
    logic          core_finish;
    logic          core_core_free;
`ifdef FRIET_ARB_CYCLE_COUNT_EN
    logic [15:0]   run_cycles;
`endif

    always #5 clk = ~clk;

    friet_permutation_arbiter dut (
        .clk                 (clk),
        .arst                (arst),
        .req                 (req),
        .gnt                 (gnt),
        .rq_data_in          (rq_data_in),
        .rq_data_in_valid    (rq_data_in_valid),
        .rq_data_in_ready    (rq_data_in_ready),
        .rq_data_out         (rq_data_out),
        .rq_data_out_valid   (rq_data_out_valid),
        .rq_data_out_ready   (rq_data_out_ready),
        .done                (done),
        .core_start          (core_start),
        .core_data_in_valid  (core_data_in_valid),
        .core_data_out_ready (core_data_out_ready),
        .core_data_in        (core_data_in),
        .core_data_out       (core_data_out),
        .core_data_out_valid (core_data_out_valid),
        .core_data_in_ready  (core_data_in_ready),
        .core_finish         (core_finish),
        .core_core_free      (core_core_free)
`ifdef FRIET_ARB_CYCLE_COUNT_EN
        ,
        .run_cycles          (run_cycles)
`endif
    );

    // ---------------- behavioural core stand-in ----------------
    logic          free_en;
    logic          spur_fin;
    logic [1:0]    cphase;     // 0 idle/load, 1 run, 2 unload
    logic [7:0]    in_buf [WORDS];
    int            in_cnt;
    int            out_idx;
    int            run_cnt;
    logic [7:0]    cyc;
    logic          model_fin;

    assign core_data_in_ready  = (cphase == 2'd0) && (in_cnt < WORDS) && (cyc % 5 != 4);
    assign core_core_free      = free_en && (cphase == 2'd0) && (in_cnt == 0);
    assign core_data_out_valid = (cphase == 2'd2) && (cyc % 6 != 5);
    assign core_finish         = model_fin | spur_fin;

    always_comb begin
        core_data_out = 8'h00;
        if (out_idx < WORDS)
            core_data_out = in_buf[WORDS - 1 - out_idx] ^ (8'h5A + 8'(out_idx));
    end

    always @(posedge clk) begin
        cyc       <= cyc + 8'd1;
        model_fin <= 1'b0;
        if (arst) begin
            cphase  <= 2'd0;
            in_cnt  <= 0;
            out_idx <= 0;
            run_cnt <= 0;
        end else begin
            case (cphase)
                2'd0: begin
                    if (core_data_in_valid && core_data_in_ready) begin
                        in_buf[in_cnt] <= core_data_in;
                        in_cnt         <= in_cnt + 1;
                    end
                    if (core_start) begin
                        cphase  <= 2'd1;
                        run_cnt <= 0;
                    end
                end
                2'd1: begin
                    run_cnt <= run_cnt + 1;
                    if (run_cnt == 5) model_fin <= 1'b1;
                    if (model_fin) begin
                        cphase  <= 2'd2;
                        out_idx <= 0;
                    end
                end
                default: begin
                    if (core_data_out_valid && core_data_out_ready) begin
                        if (out_idx == WORDS - 1) begin
                            cphase  <= 2'd0;
                            in_cnt  <= 0;
                            out_idx <= 0;
                        end else begin
                            out_idx <= out_idx + 1;
                        end
                    end
                end
            endcase
        end
    end

    initial cyc = 8'd0;

    // ---------------- checking infrastructure ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  cur_vec [WORDS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input logic [1:0] exp_gnt, input string tag);
        int n = 0;
        @(negedge clk); #1;
        while (gnt == 2'b00 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 32'(gnt), 32'(exp_gnt));
    endtask

    task automatic load_words(input int r, input int spur_at);
        int k = 0;
        int n = 0;
        logic other_bad = 1'b0;
        for (int i = 0; i < WORDS; i++) cur_vec[i] = 8'($urandom);
        while (k < WORDS && n < 600) begin
            @(negedge clk);
            spur_fin = (n == spur_at);
            rq_data_in_valid[r]     = (n % 9 != 7);
            rq_data_in[r*BL +: BL]  = cur_vec[k];
            rq_data_in_valid[1-r]   = 1'b1;
            rq_data_in[(1-r)*BL +: BL] = 8'($urandom);
            #1;
            if (rq_data_in_ready[1-r] !== 1'b0) other_bad = 1'b1;
            if (rq_data_in_valid[r] && rq_data_in_ready[r]) k++;
            n++;
        end
        chk("load_count", 32'(k), 32'(WORDS));
        chk("load_other_ready", 32'(other_bad), 32'd0);
        for (int j = 0; j < WORDS; j++)
            exp_q.push_back(cur_vec[WORDS - 1 - j] ^ (8'h5A + 8'(j)));
        @(negedge clk);
        spur_fin         = 1'b0;
        rq_data_in_valid = 2'b00;
        #1;
        chk("start_pulse", 32'(core_start), 32'd1);
        @(negedge clk); #1;
        chk("start_single", 32'(core_start), 32'd0);
    endtask

    task automatic unload_words(input int r, input bit stall, input logic [1:0] req_after);
        int j = 0;
        int n = 0;
        int stall_cnt = 0;
        logic other_bad = 1'b0;
        logic [7:0] e;
        logic [1:0] onehot;
        onehot = (r == 0) ? 2'b01 : 2'b10;
        while (j < WORDS && n < 1500) begin
            @(negedge clk);
            if (stall && j == 20 && stall_cnt < 5) begin
                rq_data_out_ready[r] = 1'b0;
                stall_cnt++;
            end else begin
                rq_data_out_ready[r] = 1'b1;
            end
            rq_data_out_ready[1-r] = 1'b1;
            #1;
            if (rq_data_out_valid[1-r] !== 1'b0) other_bad = 1'b1;
            if (rq_data_out_valid[r] && rq_data_out_ready[r]) begin
                if (exp_q.size() == 0) begin
                    chk("unload_extra_word", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("unload_word", 32'(rq_data_out), 32'(e));
                end
                j++;
            end
            n++;
        end
        chk("unload_count", 32'(j), 32'(WORDS));
        chk("unload_other_valid", 32'(other_bad), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rq_data_out_ready = 2'b00;
        #1;
        chk("done_pulse", 32'(done), 32'(onehot));
        chk("gnt_released", 32'(gnt), 32'd0);
        req = req_after;
        @(negedge clk); #1;
        chk("done_single", 32'(done), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        arst              = 1'b1;
        req               = 2'b11;
        rq_data_in        = '0;
        rq_data_in_valid  = 2'b11;
        rq_data_out_ready = 2'b11;
        free_en           = 1'b1;
        spur_fin          = 1'b0;

        // Reset held with both requesting
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_in_ready", 32'(rq_data_in_ready), 32'd0);
            chk("rst_out_valid", 32'(rq_data_out_valid), 32'd0);
        end
        @(negedge clk);
        arst = 1'b0;
        rq_data_in_valid = 2'b00;
        #1;
        chk("rst_release_gnt", 32'(gnt), 32'd0);
        @(negedge clk); #1;
        chk("first_gnt", 32'(gnt), 32'h1);

        // Four back-to-back transactions with both requesting
        load_words(0, 10);      // spurious core_finish during LOAD is ignored
        unload_words(0, 1'b0, 2'b11);
        wait_grant(2'b10, "rr_gnt_2");
        load_words(1, -1);
        unload_words(1, 1'b1, 2'b11);
        wait_grant(2'b01, "rr_gnt_3");
        load_words(0, -1);
        unload_words(0, 1'b0, 2'b11);
        wait_grant(2'b10, "rr_gnt_4");
        load_words(1, -1);
        unload_words(1, 1'b0, 2'b00);

        // Requester 0 alone, with an output stall mid-unload
        req = 2'b01;
        wait_grant(2'b01, "solo_gnt");
        load_words(0, -1);
        unload_words(0, 1'b1, 2'b00);

        // Core not free: no grant until it becomes free
        free_en = 1'b0;
        req     = 2'b10;
        repeat (5) @(negedge clk);
        #1;
        chk("busy_no_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        free_en = 1'b1;
        #1;
        chk("free_gnt_not_yet", 32'(gnt), 32'd0);
        @(negedge clk); #1;
        chk("free_gnt", 32'(gnt), 32'h2);
        load_words(1, -1);
        unload_words(1, 1'b0, 2'b00);

        // Asynchronous reset during RUN, then a clean transaction
        req = 2'b01;
        wait_grant(2'b01, "arst_pre_gnt");
        load_words(0, -1);
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_start", 32'(core_start), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_in_ready", 32'(rq_data_in_ready), 32'd0);
        chk("arst_out_valid", 32'(rq_data_out_valid), 32'd0);
        chk("arst_core_oready", 32'(core_data_out_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        arst = 1'b0;
        wait_grant(2'b01, "post_arst_gnt");
        load_words(0, -1);
        unload_words(0, 1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/friet_permutation_arbiter.md
Name: friet_permutation_arbiter

Overview:
- Shares one friet_permutation_n_rounds_with_communication core between two requesters, each with its own word-serial load/unload stream.
- Grants the core to one requester per transaction: load full state, pulse start, wait for finish, unload full state, release.
- Round-robin between the two requesters. Sits between the two clients and the core's streaming ports; contains no permutation logic.

Parameters:
- BUFFER_LENGTH, 8, stream word width in bits (must match the core).
- STATE_SIZE, 384, permutation state width; WORDS = STATE_SIZE/BUFFER_LENGTH = 48 words per direction.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- req  in  2  request per requester, level; must stay high until done
- gnt  out  2  one-hot grant, or 0
- rq_data_in  in  2*BUFFER_LENGTH  requester words; slice [i*BL +: BL] belongs to requester i
- rq_data_in_valid  in  2  per-requester input valid
- rq_data_in_ready  out  2  per-requester input ready
- rq_data_out  out  BUFFER_LENGTH  shared output word, qualified by rq_data_out_valid
- rq_data_out_valid  out  2  per-requester output valid
- rq_data_out_ready  in  2  per-requester output ready
- done  out  2  one-cycle pulse when requester i's transaction completes
- core_start, core_data_in_valid, core_data_out_ready  out  1  to core
- core_data_in  out  BUFFER_LENGTH  to core
- core_data_out  in  BUFFER_LENGTH  from core
- core_data_out_valid, core_data_in_ready, core_finish, core_core_free  in  1  from core

Behaviour:
- Reset: state IDLE, gnt=0, done=0, core_start=0, word counter=0, rr pointer=0 (requester 0 preferred). All ready/valid outputs are 0 while in reset.
- States: IDLE, LOAD, START, RUN, UNLOAD, RELEASE.
- IDLE -> LOAD when any req is set and core_core_free=1.
  - Single request: grant it.
  - Both requesting: grant the requester selected by the rr pointer.
  - gnt registers at this transition, so the grant is visible the cycle after the request.
- LOAD:
  - core_data_in = granted slice.
  - core_data_in_valid = rq_data_in_valid[g].
  - rq_data_in_ready[g] = core_data_in_ready; the other requester's ready = 0.
  - Count a word on valid&&ready. On the 48th word go to START.
- START: core_start=1 for exactly one cycle -> RUN.
- RUN: all stream handshakes held 0. Go to UNLOAD on the cycle core_finish=1.
- UNLOAD:
  - rq_data_out = core_data_out.
  - rq_data_out_valid[g] = core_data_out_valid.
  - core_data_out_ready = rq_data_out_ready[g].
  - Count 48 accepted words, then go to RELEASE.
- RELEASE (one cycle):
  - done[g]=1 for this cycle; gnt cleared.
  - rr pointer set to the other requester.
  - -> IDLE.
  - Back-to-back grant earliest 2 cycles after the last output word.
- Word counter: 6 bits, cleared on every state entry. Compare against WORDS-1 on handshake; it never wraps.
- Ungranted requester: ready/valid held 0; its rq_data_in_valid is ignored.
- req[g] dropping mid-transaction is ignored; the transaction completes. The requester must keep handshaking or the arbiter stalls, with no timeout.
- core_core_free=0 in IDLE: no grant is issued.
- core_finish outside RUN is ignored.
- arst mid-transaction: immediate return to reset values. The core is reset separately by the integrator.

Optional Feature:
- Macro: FRIET_ARB_CYCLE_COUNT_EN.
- Enabled:
  - Adds output run_cycles [15:0], a saturating counter cleared on START.
  - Increments each RUN cycle and holds its value after finish until the next START.
  - Reset value 0.
- Disabled: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package friet_pkg holds:
  - state encoding localparams (IDLE..RELEASE),
  - FRIET_STATE_SIZE=384,
  - helper constant for the word count and counter width.
- One natural sub-module: friet_rr_arbiter2, a 2-way round-robin grant picker (req, pointer -> one-hot grant).

Test Plan:
- Reset with req=2'b11 held -> gnt=0, all valids/readys 0 until arst deasserts; then gnt=2'b01.
- Requester 0 alone loads 48 words of a known vector -> exactly one core_start pulse the cycle after the 48th handshake. The 48 returned words match the reference permutation output, then done=2'b01 for one cycle.
- Both requesting continuously -> grants alternate 01,10,01,10 over four transactions. Each returns its own correct result; the ungranted requester's ready/valid stay 0 throughout.
- Requester drives rq_data_out_ready low for 5 cycles mid-unload -> no word lost or duplicated; the counter still completes at 48.
- core_core_free=0 with req=2'b10 -> gnt stays 0. Raising core_free -> gnt=2'b10 on the following cycle.
- arst pulsed during RUN -> all outputs return to reset values within the same cycle. After release, a new transaction from requester 0 completes correctly.
